// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
//   Issue stage between an operand source and the 16x16 shift-add multiplier.
//   Operand pairs are buffered in a small FIFO. One multiplication is launched
//   at a time through the multiplier's start/ready contract. The captured
//   product is then offered downstream. Results leave in FIFO order.
//
//   Handshakes: a transfer on a valid/ready port happens on a rising clk edge
//   where both valid and ready are high. valid never waits on ready. Once the
//   result port raises out_valid, out_valid and out_product hold until the
//   transfer.
//
//   Ports:
//     clk, rst          clock (rising edge), asynchronous active-high reset
//     in_valid/in_ready operand pair handshake (in_ready low while rst high)
//     in_a, in_b        multiplier / multiplicand operands
//     mul_multiplier    operand A to the multiplier, held from pop to next pop
//     mul_multiplicand  operand B to the multiplier, held from pop to next pop
//     mul_start         one-cycle launch pulse to the multiplier
//     mul_product       multiplier product (valid while mul_ready is high)
//     mul_ready         multiplier idle / product valid
//     out_valid/out_ready  result handshake
//     out_product       captured 2*WIDTH-bit unsigned product
//     timeout_err       sticky multiplier-hang flag
//
//   Build option: define MUL_TIMEOUT_EN to add a per-operation cycle limit
//   (TIMEOUT). Without it, timeout_err is tied low and the FSM waits forever.
//   The FSM state is held in state_q.
module mul_operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic               mul_start,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               timeout_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, done, tmo_hit;

  // No bypass: a full FIFO refuses input even in a cycle where it pops.
  assign in_ready = ~rst & (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == S_IDLE) & (count != '0);
  // A timeout in the same cycle as completion drops the result.
  assign done     = (state_q == S_WAIT_DONE) & mul_ready & ~tmo_hit;

  // ---------------------------------------------------------------- FIFO
  // The storage needs no reset. Only the pointers and the count define
  // which entries are occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------ optional timeout
`ifdef MUL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          in_wait;

  assign in_wait = (state_q == S_WAIT_BUSY) | (state_q == S_WAIT_DONE);
  // The counter holds the number of wait cycles already spent. The limit is
  // reached on the edge that would make it TIMEOUT.
  assign tmo_hit = in_wait & (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == S_LAUNCH) tmo_cnt <= '0;
      else if (in_wait)        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ------------------------------------------------------- FSM: state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ------------------------------------------------------ FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (count != '0) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tmo_hit)         state_d = S_IDLE;
        else if (!mul_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tmo_hit)        state_d = S_IDLE;
        else if (mul_ready) state_d = S_HOLD;
      end
      S_HOLD:      if (out_valid && out_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- FSM: outputs
  always_comb begin
    mul_start = 1'b0;
    if (state_q == S_LAUNCH) mul_start = 1'b1;
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      out_product      <= '0;
      out_valid        <= 1'b0;
    end else begin
      if (pop) begin
        mul_multiplier   <= mem_a[rd_ptr];
        mul_multiplicand <= mem_b[rd_ptr];
      end
      if (done) begin
        out_product <= mul_product;
        out_valid   <= 1'b1;
      end else if (state_q == S_HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
`timescale 1ns/1ps
module tb_mul_operand_sequencer;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;
  localparam int PW      = 2 * WIDTH;

  // ------------------------------------------------- clock / reset / DUT
  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] mul_multiplier, mul_multiplicand;
  logic             mul_start;
  logic [PW-1:0]    mul_product;
  logic             mul_ready;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_product;
  logic             timeout_err;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  logic [PW-1:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mul_operand_sequencer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_start        (mul_start),
    .mul_product      (mul_product),
    .mul_ready        (mul_ready),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .timeout_err      (timeout_err)
  );

  // ------------------------------------------------------ multiplier model
  // ready drops on the start edge, rises mul_lat edges later with the product.
  logic [WIDTH-1:0] m_a, m_b;
  logic             m_busy;
  int               m_cnt;
  int               mul_lat = 17;
  bit               m_hang  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_ready   <= 1'b1;
      mul_product <= '0;
      m_busy      <= 1'b0;
      m_cnt       <= 0;
      m_a         <= '0;
      m_b         <= '0;
    end else if (mul_start) begin
      m_a       <= mul_multiplier;
      m_b       <= mul_multiplicand;
      mul_ready <= 1'b0;
      m_busy    <= 1'b1;
      m_cnt     <= mul_lat;
    end else if (m_busy && !m_hang) begin
      if (m_cnt <= 1) begin
        mul_product <= PW'(m_a) * PW'(m_b);
        mul_ready   <= 1'b1;
        m_busy      <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && mul_start) start_cnt++;
  end

  // ------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [PW-1:0] got,
                       input logic [PW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted result must match the head of exp_q.
  always @(posedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra got=0x%0h exp=none", out_product);
      end
      if (exp_q.size() != 0) check("sb_order", out_product, exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ov(input int budget, output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // ------------------------------------------------------------- stimulus
  logic [WIDTH-1:0] fa [5];
  logic [WIDTH-1:0] fb [5];
  int cyc;
  int s0;
  int guard;

  initial begin
    fa = '{16'hFFFF, 16'd2, 16'd0, 16'd1, 16'd4};
    fb = '{16'hFFFF, 16'd7, 16'd9, 16'd1, 16'd4};
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;

    // Reset values.
    step(2);
    check("rst_in_ready", in_ready, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_out_product", out_product, 0);
    check("rst_mul_a", mul_multiplier, 0);
    rst = 1'b0;
    step();
    check("in_ready_after_rst", in_ready, 1);

    // Single op 3*5, issue and result latency.
    s0 = start_cnt;
    in_valid = 1'b1; in_a = 16'd3; in_b = 16'd5;
    exp_q.push_back(32'd15);
    step();
    in_valid = 1'b0;
    check("t1_no_start_yet", mul_start, 0);
    step();
    check("t1_start", mul_start, 1);
    check("t1_op_a", mul_multiplier, 3);
    check("t1_op_b", mul_multiplicand, 5);
    step();
    check("t1_start_one_cycle", mul_start, 0);
    wait_ov(40, cyc);
    check("t1_latency", cyc, 18);
    check("t1_valid", out_valid, 1);
    check("t1_product", out_product, 32'd15);
    step();
    check("t1_valid_one_cycle", out_valid, 0);
    step(3);
    check("t1_start_count", start_cnt - s0, 1);

    // Fill and backpressure: a result parked in HOLD stalls issue.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'd6; in_b = 16'd7;
    exp_q.push_back(32'd42);
    step();
    in_valid = 1'b0;
    wait_ov(40, cyc);
    check("t2_first_valid", out_valid, 1);
    check("t2_first_product", out_product, 32'd42);
    s0 = start_cnt;
    exp_q.push_back(32'hFFFE0001);
    exp_q.push_back(32'd14);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd16);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = fa[i]; in_b = fb[i];
      check("t2_in_ready_open", in_ready, 1);
      step();
    end
    in_a = fa[4]; in_b = fb[4];
    check("t2_in_ready_full", in_ready, 0);
    step(30);
    check("t2_hold_valid", out_valid, 1);
    check("t2_hold_product", out_product, 32'd42);
    check("t2_no_issue", start_cnt - s0, 0);
    check("t2_still_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    check("t2_handshake_clears", out_valid, 0);
    check("t2_no_start_at_hs", mul_start, 0);
    step();
    check("t2_resume_start", mul_start, 1);
    check("t2_resume_head", mul_multiplier, 16'hFFFF);
    check("t2_in_ready_reopen", in_ready, 1);
    step();
    in_valid = 1'b0;
    wait_ov(40, cyc);
    check("t2_r0_product", out_product, 32'hFFFE0001);
    step(2);
    check("t2_b2b_start", mul_start, 1);
    check("t2_b2b_op", mul_multiplier, 2);
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      step();
      guard++;
    end
    check("t2_drained", exp_q.size(), 0);

    // Reset while in WAIT_DONE with two pairs queued.
    in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9;
    step();
    in_a = 16'd1; in_b = 16'd2;
    step();
    in_a = 16'd3; in_b = 16'd4;
    step();
    in_valid = 1'b0;
    step(4);
    rst = 1'b1;
    #1;
    check("t3_rst_start", mul_start, 0);
    check("t3_rst_valid", out_valid, 0);
    check("t3_rst_product", out_product, 0);
    check("t3_rst_mul_a", mul_multiplier, 0);
    check("t3_rst_mul_b", mul_multiplicand, 0);
    check("t3_rst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    s0 = start_cnt;
    step(30);
    check("t3_no_start_after", start_cnt - s0, 0);
    check("t3_no_valid_after", out_valid, 0);
    check("t3_in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = 16'd3; in_b = 16'd3;
    exp_q.push_back(32'd9);
    step();
    in_valid = 1'b0;
    wait_ov(60, cyc);
    check("t3_recover_product", out_product, 32'd9);
    step(2);

    // Multiplier that never raises ready.
`ifdef MUL_TIMEOUT_EN
    m_hang = 1'b1;
    in_valid = 1'b1; in_a = 16'd5; in_b = 16'd5;
    step();
    in_a = 16'd2; in_b = 16'd3;
    exp_q.push_back(32'd6);
    step();
    in_valid = 1'b0;
    check("t4_launch_op", mul_multiplier, 5);
    step();
    step(39);
    check("t4_err_before", timeout_err, 0);
    step();
    check("t4_err_set", timeout_err, 1);
    check("t4_no_valid", out_valid, 0);
    m_hang = 1'b0;
    step();
    check("t4_next_launch", mul_start, 1);
    check("t4_next_op", mul_multiplier, 2);
    wait_ov(60, cyc);
    check("t4_next_product", out_product, 32'd6);
    step(3);
    check("t4_err_sticky", timeout_err, 1);
`else
    m_hang = 1'b1;
    in_valid = 1'b1; in_a = 16'd5; in_b = 16'd5;
    step();
    in_valid = 1'b0;
    step(60);
    check("t4_no_timeout_flag", timeout_err, 0);
    check("t4_stuck_no_valid", out_valid, 0);
    check("t4_stuck_in_ready", in_ready, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_hang = 1'b0;
    step(2);
`endif

    check("final_sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
